// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host register read/write commands and issues them one at a time to the I2C byte master.
// Define I2C_SEQ_RETRY_EN to reissue nacked or arbitration-lost commands up to MAX_RETRY times.
module i2c_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [6:0] cmd_addr7,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err,
    output logic [1:0] rsp_retries,
    output logic       m_start,
    output logic       m_rw,
    output logic [6:0] m_addr7,
    output logic [7:0] m_reg_addr,
    output logic [7:0] m_data_in,
    output logic       m_do_read,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ack_err,
    input  logic       m_arb_lost,
    input  logic [7:0] m_read_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Counter runs from 0 after ISSUE, so this hit lands the response exactly TIMEOUT_CYCLES after m_start.
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, HOLD} state_t;

    state_t        state_q;
    logic [23:0]   mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
    logic [TW-1:0] wd_q;
    logic [7:0]    data_q;
    logic [1:0]    err_q;
    logic [23:0]   head;
    logic          push, pop, empty, wd_hit;

    assign m_rw   = 1'b0;
    assign push   = cmd_valid && cmd_ready;
    assign pop    = state_q == RESP;
    assign wr_d   = wr_q + (AW+1)'(push);
    assign rd_d   = rd_q + (AW+1)'(pop);
    assign empty  = wr_q == rd_q;
    assign head   = mem_q[rd_q[AW-1:0]];
    assign wd_hit = wd_q == WD_LAST;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2;
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
    logic [RW-1:0] retry_q;
`else
    assign rsp_retries = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {cmd_read, cmd_addr7, cmd_reg, cmd_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cmd_ready <= 1'b1;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cmd_ready <= (wr_d ^ rd_d) != {1'b1, {AW{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            m_start     <= 1'b0;
            m_addr7     <= '0;
            m_reg_addr  <= '0;
            m_data_in   <= '0;
            m_do_read   <= 1'b0;
            wd_q        <= '0;
            data_q      <= '0;
            err_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= '0;
            rsp_retries <= '0;
`endif
        end else begin
            m_start <= 1'b0;
            case (state_q)
                IDLE: if (!empty && !rsp_valid && !m_busy) state_q <= ISSUE;
                ISSUE: begin
                    m_start <= 1'b1;
                    {m_do_read, m_addr7, m_reg_addr, m_data_in} <= head;
                    wd_q    <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    wd_q <= wd_q + 1'b1;
                    if (wd_hit) begin
                        err_q   <= 2'b11;
                        data_q  <= 8'h00;
                        state_q <= RESP;
                    end else if (m_busy) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wd_q <= wd_q + 1'b1;
                    if (m_done) begin
                        data_q <= m_do_read ? m_read_data : 8'h00;
                        err_q  <= m_arb_lost ? 2'b10 : {1'b0, m_ack_err};
`ifdef I2C_SEQ_RETRY_EN
                        if ((m_arb_lost || m_ack_err) && retry_q < MAX_R) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= IDLE;
                        end else
`endif
                        state_q <= RESP;
                    end else if (wd_hit) begin
                        err_q   <= 2'b11;
                        data_q  <= 8'h00;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= data_q;
                    rsp_err   <= err_q;
`ifdef I2C_SEQ_RETRY_EN
                    rsp_retries <= (retry_q > RW'(3)) ? 2'd3 : retry_q[1:0];
                    retry_q     <= '0;
`endif
                    state_q <= HOLD;
                end
                HOLD: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
